harq_send_reader: RTL and testbench

Reads one combined code block out of the HARQ Ping or Pong soft-combining buffer and streams it downstream as saturated 8-bit LLRs.
- On a send request it generates sequential SRAM read addresses and tracks the 1-cycle synchronous read latency.
- Each 160-bit word (16 × 10-bit signed sums) is saturated to 16 × 8-bit and pushed into a 4-entry output FIFO with valid/ready backpressure.
- A one-cycle completion pulse is issued after the last beat is accepted, releasing the combiner from its WAIT state.

---
 rtl/harq_send_reader_if.sv | 13 +
 rtl/harq_send_reader.sv | 139 +++++++++++++
 tb/tb_harq_send_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/harq_send_reader_if.sv
// rtl/harq_send_reader_if.sv - saturated LLR output stream between reader and downstream consumer
interface harq_send_reader_if #(
    parameter int LANES = 16,
    parameter int OUT_W = 8
);
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [LANES*OUT_W-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/harq_send_reader.sv
// rtl/harq_send_reader.sv - streams one HARQ Ping/Pong code block out as saturated 8-bit LLRs
module harq_send_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int LANES      = 16,
    parameter int IN_W       = 10,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_SENDHARQ_Data_request,
    input  logic                     i_SENDHARQ_Data_PingPong_Indicator,
    input  logic [15:0]              i_SENDHARQ_Data_ncb,
    output logic [ADDR_WIDTH-1:0]    o_SENDHARQ_Data_Address,
    input  logic [LANES*IN_W-1:0]    i_Ping_Read_Data,
    input  logic [LANES*IN_W-1:0]    i_Pong_Read_Data,
    output logic                     o_SENDHARQ_Data_Comp,
    output logic                     o_busy,
    harq_send_reader_if.master       out_if
);
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        READ  = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] MAX_ADDR = (32'd1 << ADDR_WIDTH) - 32'd1;
    localparam int SMAX = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(SMAX);
    localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;

    state_t                  state;
    logic                    sel;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    inflight;
    logic                    inflight_last;
    logic                    comp;

    logic [LANES*OUT_W:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic [31:0]             ncb_words;
    logic [LANES*IN_W-1:0]   rd_word;
    logic [LANES*OUT_W-1:0]  sat_word;
    logic                    issue;
    logic                    pop;

    // Credit counts the read in flight so the FIFO can never overflow, whatever ready does
    assign issue     = (state == READ) && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
    assign pop       = out_if.tvalid && out_if.tready;
    assign ncb_words = 32'(i_SENDHARQ_Data_ncb) >> 4;
    assign rd_word   = sel ? i_Pong_Read_Data : i_Ping_Read_Data;

    assign out_if.tvalid              = (count != '0);
    assign {out_if.tlast, out_if.tdata} = fifo_mem[rd_ptr];
    assign o_busy                     = (state != IDLE);
    assign o_SENDHARQ_Data_Address    = addr;
    assign o_SENDHARQ_Data_Comp       = comp;

    function automatic logic [OUT_W-1:0] sat(input logic signed [IN_W-1:0] v);
        if (v > POS_LIM)      return POS_LIM[OUT_W-1:0];
        else if (v < NEG_LIM) return NEG_LIM[OUT_W-1:0];
        else                  return v[OUT_W-1:0];
    endfunction

    always_comb begin
        sat_word = '0;
        for (int i = 0; i < LANES; i++) begin
            sat_word[i*OUT_W +: OUT_W] = sat(rd_word[i*IN_W +: IN_W]);
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state         <= IDLE;
            sel           <= 1'b0;
            last_addr     <= '0;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            comp          <= 1'b0;
        end else begin
            comp          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (addr == last_addr);
            case (state)
                IDLE: begin
                    if (i_SENDHARQ_Data_request) begin
                        sel       <= i_SENDHARQ_Data_PingPong_Indicator;
                        last_addr <= (ncb_words > MAX_ADDR) ? MAX_ADDR[ADDR_WIDTH-1:0]
                                                            : ncb_words[ADDR_WIDTH-1:0];
                        addr      <= '0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr == last_addr) state <= DRAIN;
                        else                   addr  <= addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (!inflight && (count == '0)) begin
                        state <= DONE;
                        comp  <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= {inflight_last, sat_word};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(inflight) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_harq_send_reader.sv
// tb/tb_harq_send_reader.sv - scoreboard bench for harq_send_reader
module tb_harq_send_reader;
    localparam int AW    = 11;
    localparam int LANES = 16;
    localparam int IN_W  = 10;
    localparam int OUT_W = 8;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  req = 1'b0;
    logic                  ind = 1'b0;
    logic [15:0]           ncb = 16'd0;
    logic [AW-1:0]         addr;
    logic [LANES*IN_W-1:0] ping_q;
    logic [LANES*IN_W-1:0] pong_q;
    logic                  comp;
    logic                  busy;

    harq_send_reader_if #(.LANES(LANES), .OUT_W(OUT_W)) out_if ();

    harq_send_reader #(
        .ADDR_WIDTH(AW), .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(4)
    ) dut (
        .i_core_clk                         (clk),
        .i_rx_rstn                          (rstn),
        .i_SENDHARQ_Data_request            (req),
        .i_SENDHARQ_Data_PingPong_Indicator (ind),
        .i_SENDHARQ_Data_ncb                (ncb),
        .o_SENDHARQ_Data_Address            (addr),
        .i_Ping_Read_Data                   (ping_q),
        .i_Pong_Read_Data                   (pong_q),
        .o_SENDHARQ_Data_Comp               (comp),
        .o_busy                             (busy),
        .out_if                             (out_if)
    );

    always #5 clk = ~clk;

    logic [LANES*IN_W-1:0] ping_mem [2048];
    logic [LANES*IN_W-1:0] pong_mem [2048];
    always @(posedge clk) begin
        ping_q <= ping_mem[addr];
        pong_q <= pong_mem[addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;
    logic [128:0] exp_q [$];
    int comp_seen = 0;
    int comp_cyc = 0;
    int fv = -1;
    int acc_blk = 0;
    int max_lead = 0;
    int rmode = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fill_exp(input int a);
        logic [127:0] w;
        for (int i = 0; i < LANES; i++) w[i*8 +: 8] = 8'((a + i) & 127);
        return w;
    endfunction

    // Monitor: pops the scoreboard on every handshake, tracks Comp and address lead
    initial begin
        logic prev_comp;
        logic [128:0] e;
        int lead;
        prev_comp = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (comp) begin
                    comp_seen++;
                    comp_cyc = cyc;
                    chk("comp_one_cycle", 160'(prev_comp), 160'(0));
                end
                prev_comp = comp;
                if (out_if.tvalid && fv < 0) fv = cyc;
                if (out_if.tvalid && out_if.tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 160'(1), 160'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 160'({out_if.tlast, out_if.tdata}), 160'(e));
                    end
                    acc_blk++;
                end
                if (busy) begin
                    lead = int'(addr) - acc_blk;
                    if (lead > max_lead) max_lead = lead;
                end
            end else begin
                prev_comp = 1'b0;
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        out_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) out_if.tready = ((ph % 4) == 0) || ((ph % 4) == 3);
            else            out_if.tready = 1'b1;
            ph++;
        end
    end

    task automatic start(input logic s, input logic [15:0] n, output int t0);
        @(negedge clk);
        ind = s; ncb = n; req = 1'b1;
        fv = -1; acc_blk = 0; max_lead = 0;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        req = 1'b0; ind = ~s; ncb = n ^ 16'h0010;
    endtask

    task automatic wait_comp(input int budget, input string name);
        int c0;
        c0 = comp_seen;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (comp_seen > c0) break;
        end
        chk(name, 160'(comp_seen - c0), 160'(1));
    endtask

    int sat_in [16] = '{511, -512, 127, -128, 128, -127, 0, -1, 200, -200, 5, -5, 300, -300, 100, -100};

    initial begin
        int t0;
        int c0;
        for (int a = 0; a < 2048; a++) begin
            for (int i = 0; i < LANES; i++) ping_mem[a][i*IN_W +: IN_W] = 10'((a + i) & 127);
            pong_mem[a] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            pong_mem[0][i*IN_W +: IN_W] = 10'(sat_in[i]);
            pong_mem[1][i*IN_W +: IN_W] = 10'(120 + i);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 160'(out_if.tvalid), 160'(0));
        chk("rst_busy",  160'(busy), 160'(0));
        chk("rst_comp",  160'(comp), 160'(0));
        chk("rst_addr",  160'(addr), 160'(0));
        chk("rst_data",  160'({out_if.tlast, out_if.tdata}), 160'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Basic: 5 words, latency and completion timing
        for (int a = 0; a < 5; a++) exp_q.push_back({a == 4, fill_exp(a)});
        start(1'b0, 16'd64, t0);
        wait_comp(40, "comp_basic");
        chk("first_valid_lat", 160'(fv - t0), 160'(2));
        chk("comp_lat", 160'(comp_cyc - t0), 160'(8));
        chk("drained_basic", 160'(exp_q.size()), 160'(0));
        #1;
        chk("busy_after_done", 160'(busy), 160'(0));

        // Saturation from Pong
        exp_q.push_back({1'b0, 128'h9C64817FFB05817F_FF00817F817F817F});
        exp_q.push_back({1'b1, 128'h7F7F7F7F7F7F7F7F_7F7E7D7C7B7A7978});
        start(1'b1, 16'd16, t0);
        wait_comp(40, "comp_sat");
        chk("drained_sat", 160'(exp_q.size()), 160'(0));

        // Backpressure 1,0,0,1
        rmode = 1;
        for (int a = 0; a < 11; a++) exp_q.push_back({a == 10, fill_exp(a)});
        start(1'b0, 16'd160, t0);
        wait_comp(200, "comp_bp");
        chk("lead_le_4", 160'(max_lead <= 4), 160'(1));
        chk("beats_bp", 160'(acc_blk), 160'(11));
        chk("drained_bp", 160'(exp_q.size()), 160'(0));
        rmode = 0;

        // Clamp to 2048 words
        for (int a = 0; a < 2048; a++) exp_q.push_back({a == 2047, fill_exp(a)});
        start(1'b0, 16'hFFFF, t0);
        wait_comp(2300, "comp_clamp");
        chk("beats_clamp", 160'(acc_blk), 160'(2048));
        chk("addr_hold_clamp", 160'(addr), 160'(2047));
        chk("drained_clamp", 160'(exp_q.size()), 160'(0));

        // Single word
        exp_q.push_back({1'b1, fill_exp(0)});
        start(1'b0, 16'd15, t0);
        wait_comp(40, "comp_single");
        chk("beats_single", 160'(acc_blk), 160'(1));

        // Second request mid-block is ignored
        for (int a = 0; a < 5; a++) exp_q.push_back({a == 4, fill_exp(a)});
        start(1'b0, 16'd64, t0);
        @(negedge clk);
        req = 1'b1; ncb = 16'd15;
        @(negedge clk);
        req = 1'b0;
        wait_comp(40, "comp_ignore");
        c0 = comp_seen;
        repeat (10) @(posedge clk);
        #1;
        chk("no_restart_busy", 160'(busy), 160'(0));
        chk("no_restart_comp", 160'(comp_seen - c0), 160'(0));
        chk("beats_ignore", 160'(acc_blk), 160'(5));

        // Reset at beat 3
        for (int a = 0; a < 11; a++) exp_q.push_back({a == 10, fill_exp(a)});
        start(1'b0, 16'd160, t0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_blk >= 3) break;
        end
        chk("reach_beat3", 160'(acc_blk >= 3), 160'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", 160'(out_if.tvalid), 160'(0));
        chk("rst_mid_busy", 160'(busy), 160'(0));
        exp_q.delete();
        c0 = comp_seen;
        repeat (20) @(posedge clk);
        chk("rst_no_comp", 160'(comp_seen - c0), 160'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Fresh request after reset starts from address 0
        exp_q.push_back({1'b1, fill_exp(0)});
        start(1'b0, 16'd15, t0);
        chk("fresh_addr", 160'(addr), 160'(0));
        wait_comp(40, "comp_fresh");
        chk("fresh_lat", 160'(fv - t0), 160'(2));
        chk("drained_fresh", 160'(exp_q.size()), 160'(0));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
